// File: rtl/sd_spi_pkg.sv
// ============================================================================
// Module : sd_spi_pkg
// Brief  : Shared types and constants for the SD card SPI-mode byte engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sd_spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam logic [6:0] CRC7_POLY   = 7'h09;
    // ClkDiv presets for a 50 MHz CK: ~397 kHz card init clock and 25 MHz data clock
    localparam int         SD_DIV_400K = 62;
    localparam int         SD_DIV_25M  = 0;

endpackage

`default_nettype wire

// File: rtl/sd_spi_crc7.sv
// ============================================================================
// Module : sd_spi_crc7
// Brief  : Bit-serial CRC7 (x^7 + x^3 + 1) with synchronous clear and enable.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sd_spi_crc7
    import sd_spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic w_fb;

    assign w_fb = crc[6] ^ bit_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 7'h00;
        end else if (clr) begin
            crc <= 7'h00;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);
        end
    end

endmodule

`default_nettype wire

// File: rtl/sd_spi_master.sv
// ============================================================================
// Module : sd_spi_master
// Brief  : SPI mode-0, MSB-first byte engine driving the SD slot pads.
//          Optional CRC7 generator on MOSI enabled by macro SD_SPI_CRC7_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sd_spi_master
    import sd_spi_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             CK,
    input  logic             RSTN,
    input  logic [DIV_W-1:0] ClkDiv,
    input  logic             CsAssert,
    input  logic             TxValid,
    output logic             TxReady,
    input  logic [7:0]       TxData,
    output logic             RxValid,
    output logic [7:0]       RxData,
    output logic             Busy,
`ifdef SD_SPI_CRC7_EN
    input  logic             CrcClr,
    output logic [6:0]       Crc7,
`endif
    output logic             SdCk,
    output logic             SdCmdOut,
    output logic             SdCmdEn,
    input  logic             SdDat0In,
    output logic             SdDat0Out,
    output logic             SdDat0En,
    output logic             SdDat3Out,
    output logic             SdDat3En
);

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_hcnt;
    logic [2:0]       r_bcnt;
    logic [6:0]       r_tx_sh;
    logic [7:0]       r_rx_sh;
    logic             w_half_done;

    assign w_half_done = (r_hcnt == r_div);
    assign SdDat0Out   = 1'b0;
    assign SdDat0En    = 1'b0;

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            r_state   <= IDLE;
            r_div     <= '0;
            r_hcnt    <= '0;
            r_bcnt    <= 3'd0;
            r_tx_sh   <= 7'd0;
            r_rx_sh   <= 8'd0;
            SdCk      <= 1'b0;
            SdCmdOut  <= 1'b1;
            SdCmdEn   <= 1'b0;
            SdDat3Out <= 1'b1;
            SdDat3En  <= 1'b0;
            TxReady   <= 1'b1;
            RxValid   <= 1'b0;
            RxData    <= 8'd0;
            Busy      <= 1'b0;
        end else begin
            RxValid  <= 1'b0;
            SdCmdEn  <= 1'b1;
            SdDat3En <= 1'b1;
            case (r_state)
                IDLE: begin
                    // CS only follows the request between bytes
                    SdDat3Out <= ~CsAssert;
                    if (TxValid && TxReady) begin
                        SdCmdOut <= TxData[7];
                        r_tx_sh  <= TxData[6:0];
                        r_div    <= ClkDiv;
                        r_hcnt   <= '0;
                        r_bcnt   <= 3'd0;
                        TxReady  <= 1'b0;
                        Busy     <= 1'b1;
                        r_state  <= LOW;
                    end
                end
                LOW: begin
                    if (w_half_done) begin
                        r_hcnt  <= '0;
                        SdCk    <= 1'b1;
                        r_rx_sh <= {r_rx_sh[6:0], SdDat0In};
                        r_state <= HIGH;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (w_half_done) begin
                        r_hcnt <= '0;
                        SdCk   <= 1'b0;
                        if (r_bcnt == 3'd7) begin
                            SdCmdOut <= 1'b1;
                            RxData   <= r_rx_sh;
                            RxValid  <= 1'b1;
                            TxReady  <= 1'b1;
                            Busy     <= 1'b0;
                            r_state  <= IDLE;
                        end else begin
                            SdCmdOut <= r_tx_sh[6];
                            r_tx_sh  <= {r_tx_sh[5:0], 1'b0};
                            r_bcnt   <= r_bcnt + 3'd1;
                            r_state  <= LOW;
                        end
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SD_SPI_CRC7_EN
    logic w_crc_en;
    logic w_crc_clr;

    // The CRC sees each MOSI bit on the same CK edge the card samples it
    assign w_crc_en  = (r_state == LOW) && w_half_done;
    assign w_crc_clr = CrcClr && (r_state == IDLE);

    sd_spi_crc7 u_crc7 (
        .clk    (CK),
        .rst_n  (RSTN),
        .clr    (w_crc_clr),
        .en     (w_crc_en),
        .bit_in (SdCmdOut),
        .crc    (Crc7)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_sd_spi_master.sv
// ============================================================================
// Module : tb_sd_spi_master
// Brief  : Self-checking bench for sd_spi_master (CRC7 checks with SD_SPI_CRC7_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sd_spi_master;
    import sd_spi_pkg::*;

    logic       CK = 1'b0;
    logic       RSTN = 1'b0;
    logic [7:0] ClkDiv;
    logic       CsAssert;
    logic       TxValid;
    logic       TxReady;
    logic [7:0] TxData;
    logic       RxValid;
    logic [7:0] RxData;
    logic       Busy;
    logic       SdCk;
    logic       SdCmdOut;
    logic       SdCmdEn;
    logic       SdDat0In;
    logic       SdDat0Out;
    logic       SdDat0En;
    logic       SdDat3Out;
    logic       SdDat3En;
`ifdef SD_SPI_CRC7_EN
    logic       CrcClr;
    logic [6:0] Crc7;
`endif

    logic loop_en;
    logic miso;
    assign SdDat0In = loop_en ? SdCmdOut : miso;

    sd_spi_master #(.DIV_W(8)) dut (
        .CK        (CK),
        .RSTN      (RSTN),
        .ClkDiv    (ClkDiv),
        .CsAssert  (CsAssert),
        .TxValid   (TxValid),
        .TxReady   (TxReady),
        .TxData    (TxData),
        .RxValid   (RxValid),
        .RxData    (RxData),
        .Busy      (Busy),
`ifdef SD_SPI_CRC7_EN
        .CrcClr    (CrcClr),
        .Crc7      (Crc7),
`endif
        .SdCk      (SdCk),
        .SdCmdOut  (SdCmdOut),
        .SdCmdEn   (SdCmdEn),
        .SdDat0In  (SdDat0In),
        .SdDat0Out (SdDat0Out),
        .SdDat0En  (SdDat0En),
        .SdDat3Out (SdDat3Out),
        .SdDat3En  (SdDat3En)
    );

    always #10 CK = ~CK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // SdCk,SdCmdOut,SdCmdEn,SdDat3Out,SdDat3En,SdDat0Out,SdDat0En,TxReady,RxValid,Busy
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_outs"}, int'({SdCk, SdCmdOut, SdCmdEn, SdDat3Out, SdDat3En,
                                  SdDat0Out, SdDat0En, TxReady, RxValid, Busy}),
            int'(10'b0101000100));
        chk({tag, "_rxdata"}, int'(RxData), 0);
    endtask

    logic [7:0] rx, mosi;
    int lat, rises, badw, badm, badb;

    // Runs one byte starting #1 after a CK edge with the engine idle.
    task automatic xfer(input logic [7:0] data, input logic [7:0] div, input logic [7:0] pat);
        int   last_chg;
        logic pck, pmo;
        TxData = data; ClkDiv = div; TxValid = 1'b1; miso = pat[7];
        rx = 8'd0; mosi = 8'd0; lat = -1; rises = 0; badw = 0; badm = 0; badb = 0;
        last_chg = 1;
        pck = SdCk; pmo = SdCmdOut;
        @(posedge CK); #1;
        TxValid = 1'b0;
        for (int n = 1; n <= 2000; n++) begin
            if (SdCk != pck) begin
                if (n - last_chg != int'(div) + 1) badw++;
                last_chg = n;
                if (SdCk) begin
                    mosi = {mosi[6:0], SdCmdOut};
                    rises++;
                    if (rises < 8) miso = pat[7-rises];
                end
            end
            if (n > 1 && SdCmdOut != pmo && !(pck && !SdCk)) badm++;
            if (RxValid) begin
                lat = n;
                rx  = RxData;
                break;
            end
            if (!Busy || TxReady) badb++;
            pck = SdCk; pmo = SdCmdOut;
            @(posedge CK); #1;
        end
        if (lat < 0) $display("FAIL xfer_timeout actual=%0h required=%0h", lat, 1);
        @(posedge CK); #1;
        chk("rxvalid_pulse", int'(RxValid), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] div;
        logic [7:0] pat;
        logic       loop;
        logic [7:0] exp_rx;
        int         exp_lat;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=%0h required=%0h", 0, 1);
        $fatal(1);
    end

    initial begin
        int first_t, second_t, bad;
        logic [7:0] first_d, second_d;

        tbl[0] = '{8'hFF, 8'd62, 8'hFF, 1'b0, 8'hFF, 1009};
        tbl[1] = '{8'h40, 8'd3,  8'h01, 1'b0, 8'h01, 65};
        tbl[2] = '{8'hA5, 8'd0,  8'h00, 1'b1, 8'hA5, 17};
        tbl[3] = '{8'h3C, 8'd0,  8'h00, 1'b1, 8'h3C, 17};
        tbl[4] = '{8'h69, 8'd1,  8'h96, 1'b0, 8'h96, 33};
        tbl[5] = '{8'h00, 8'd2,  8'h5A, 1'b0, 8'h5A, 49};

        ClkDiv = 8'd0; CsAssert = 1'b0; TxValid = 1'b0; TxData = 8'd0;
        miso = 1'b1; loop_en = 1'b0;
`ifdef SD_SPI_CRC7_EN
        CrcClr = 1'b0;
`endif
        #25;
        chk_reset_vals("reset");
        RSTN = 1'b1;
        @(posedge CK); #1;
        chk("pad_enables", int'({SdCmdEn, SdDat3En}), 3);
        CsAssert = 1'b1;
        @(posedge CK); #1;
        chk("cs_assert", int'(SdDat3Out), 0);
        chk("idle_ck_mosi", int'({SdCk, SdCmdOut, TxReady, Busy}), 4'b0110);

        for (int i = 0; i < 6; i++) begin
            loop_en = tbl[i].loop;
            xfer(tbl[i].data, tbl[i].div, tbl[i].pat);
            chk($sformatf("v%0d_rxdata", i), int'(rx), int'(tbl[i].exp_rx));
            chk($sformatf("v%0d_latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("v%0d_mosi", i), int'(mosi), int'(tbl[i].data));
            chk($sformatf("v%0d_rises", i), rises, 8);
            chk($sformatf("v%0d_width", i), badw, 0);
            chk($sformatf("v%0d_mosi_edge", i), badm, 0);
            chk($sformatf("v%0d_busy", i), badb, 0);
        end

        // Back-to-back: TxValid held, second byte accepted in the RxValid cycle
        loop_en = 1'b1; ClkDiv = 8'd0; TxData = 8'hA5; TxValid = 1'b1;
        first_t = -1; second_t = -1; first_d = 8'd0; second_d = 8'd0;
        for (int n = 1; n <= 80; n++) begin
            @(posedge CK); #1;
            if (n == 1) TxData = 8'h3C;
            if (first_t >= 0 && n == first_t + 1) TxValid = 1'b0;
            if (RxValid) begin
                if (first_t < 0) begin first_t = n; first_d = RxData; end
                else if (second_t < 0) begin second_t = n; second_d = RxData; end
            end
        end
        TxValid = 1'b0;
        chk("b2b_first_t", first_t, 17);
        chk("b2b_first_d", int'(first_d), 8'hA5);
        chk("b2b_second_t", second_t, 34);
        chk("b2b_second_d", int'(second_d), 8'h3C);

        // CsAssert and ClkDiv changes mid-byte are held off until IDLE
        loop_en = 1'b0; miso = 1'b1; ClkDiv = 8'd3; TxData = 8'h81; TxValid = 1'b1;
        bad = 0;
        @(posedge CK); #1;
        TxValid = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            if (n == 20) begin CsAssert = 1'b0; ClkDiv = 8'd0; end
            if (n <= 65 && SdDat3Out !== 1'b0) bad++;
            if (n == 65) chk("cs_rxvalid_65", int'(RxValid), 1);
            if (n == 66) chk("cs_release_66", int'(SdDat3Out), 1);
            @(posedge CK); #1;
        end
        chk("cs_held", bad, 0);
        CsAssert = 1'b1;
        @(posedge CK); #1;
        @(posedge CK); #1;

        // Reset in the middle of a byte
        ClkDiv = 8'd3; TxData = 8'h55; TxValid = 1'b1;
        @(posedge CK); #1;
        TxValid = 1'b0;
        for (int n = 1; n < 40; n++) begin
            @(posedge CK); #1;
        end
        RSTN = 1'b0;
        #1;
        chk_reset_vals("midrst");
        bad = 0;
        for (int n = 0; n < 3; n++) begin
            @(posedge CK); #1;
            if (RxValid) bad++;
        end
        RSTN = 1'b1;
        for (int n = 0; n < 70; n++) begin
            @(posedge CK); #1;
            if (RxValid) bad++;
        end
        chk("midrst_no_rxvalid", bad, 0);
        chk("midrst_cs", int'(SdDat3Out), 0);
        loop_en = 1'b1;
        xfer(8'h55, 8'd3, 8'h00);
        chk("post_rst_rxdata", int'(rx), 8'h55);
        chk("post_rst_latency", lat, 65);

`ifdef SD_SPI_CRC7_EN
        CrcClr = 1'b1;
        @(posedge CK); #1;
        CrcClr = 1'b0;
        chk("crc_clear", int'(Crc7), 0);
        xfer(8'h40, 8'd0, 8'h00);
        for (int i = 0; i < 4; i++) xfer(8'h00, 8'd0, 8'h00);
        chk("crc_cmd0", int'(Crc7), 7'h4A);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
